// File: rtl/secuenciador_parametros_pkg.sv
// Shared parameter package for the RTC register blocks: sequencer state
// encoding and default register count / ack timeout.
package secuenciador_parametros_pkg;

  localparam int unsigned N_REG_DEF  = 9;
  localparam int unsigned TO_CYC_DEF = 16;
  localparam int unsigned CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STEP   = 2'd2,
    DONE   = 2'd3
  } estado_e;

endpackage

// File: rtl/secuenciador_parametros_onehot.sv
// One-hot decoder with enable: drives exactly one write-enable bit for the
// addressed register while enabled, none otherwise.
module decodificador_onehot #(
  parameter int unsigned AW = 4,
  parameter int unsigned N  = 9
) (
  input  logic          en_i,
  input  logic [AW-1:0] idx_i,
  output logic [N-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      onehot_o[i] = en_i && (idx_i == AW'(i));
    end
  end

endmodule

// File: rtl/secuenciador_parametros.sv
// Parameter-register write sequencer: sweeps all registers or writes a single
// one, handshaking each write with ack and flagging bad addresses / timeouts.
module secuenciador_parametros
  import secuenciador_parametros_pkg::*;
#(
  parameter int unsigned N_REG  = N_REG_DEF,
  parameter int unsigned AW     = $clog2(N_REG),
  parameter int unsigned TO_CYC = TO_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [AW-1:0]    addr,
  input  logic             ack,
  input  logic             abort,
  output logic [N_REG-1:0] habilita,
  output logic [AW-1:0]    idx,
  output logic             busy,
  output logic             listo,
  output logic             err
);

  localparam logic [AW:0]      N_REG_EXT = (AW+1)'(N_REG);
  localparam logic [AW-1:0]    LAST_IDX  = AW'(N_REG - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_CYC - 1);

  estado_e          state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; abort outranks ack, which outranks the timeout
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (!mode) begin
            mode_d  = 1'b0;
            idx_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = ACTIVE;
          end else if ({1'b0, addr} < N_REG_EXT) begin
            mode_d  = 1'b1;
            idx_d   = addr;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = ACTIVE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (ack) begin
          state_d = (!mode_q && (idx_q != LAST_IDX)) ? STEP : DONE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STEP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + AW'(1);
          cnt_d   = '0;
          state_d = ACTIVE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode registered state only, so reset clears them immediately
  decodificador_onehot #(
    .AW (AW),
    .N  (N_REG)
  ) u_dec (
    .en_i     (state_q == ACTIVE),
    .idx_i    (idx_q),
    .onehot_o (habilita)
  );

  assign idx   = idx_q;
  assign busy  = (state_q != IDLE);
  assign listo = (state_q == DONE);
  assign err   = err_q;

endmodule
